ibus_uart_tx: RTL

//  Responder (target) on the 16-bit ibus driven by the CPU's dma block: decodes ibus_ren/ibus_wen
//  in a 4-word window and serves a TX FIFO, status, baud divider and control register.

---
 rtl/ibus_uart_tx_pkg.sv | 43 ++++
 rtl/ibus_uart_tx_if.sv | 26 ++
 rtl/ibus_tx_fifo.sv | 67 ++++++
 rtl/ibus_uart_tx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ibus_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibus_uart_tx_pkg
//  Description : Register offsets, bit positions, TX FSM states and the
//                address-window decode helper for the ibus UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ibus_uart_tx_pkg;

  // Register offsets within the 4-word window
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // STATUS bit positions (count field occupies [7:4])
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  // CTRL bit positions
  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IRQEN = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Returns {hit, offset}; the subtraction wraps so addresses below the base
  // land far outside the window rather than aliasing into it.
  function automatic logic [2:0] win_decode(input logic [17:0] adr, input logic [17:0] base);
    logic [17:0] diff;
    diff = adr - base;
    return {(diff[17:2] == 16'd0), diff[1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibus_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ibus_uart_tx_if
//  Description : 16-bit ibus read/write strobes, addresses and data as seen
//                by a responder; master = dma side, slave = peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ibus_uart_tx_if;
  logic        ibus_ren;
  logic [17:0] ibus_radr;
  logic [15:0] ibus32_rdata;
  logic        ibus_wen;
  logic [17:0] ibus_wadr;
  logic [15:0] ibus32_wdata;

  modport master (
    output ibus_ren, ibus_radr, ibus_wen, ibus_wadr, ibus32_wdata,
    input  ibus32_rdata
  );

  modport slave (
    input  ibus_ren, ibus_radr, ibus_wen, ibus_wadr, ibus32_wdata,
    output ibus32_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ibus_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ibus_tx_fifo
//  Description : Synchronous FIFO with push/pop/flush. count is one bit wider
//                than the pointers, so its MSB alone signals full.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibus_tx_fifo #(
  parameter int FIFO_AW = 4,
  parameter int WIDTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   push_data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [WIDTH-1:0]   pop_data_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o
);

  logic [WIDTH-1:0]   mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               full;
  logic               do_pop;
  logic               do_push;

  assign full    = count_q[FIFO_AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when paired with a pop. Flush overrides both.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full | do_pop) & ~flush_i;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; pointers wrap naturally at 2**FIFO_AW
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/ibus_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ibus_uart_tx
//  Description : ibus responder with TX FIFO, STATUS, BAUDDIV and CTRL
//                registers; drains the FIFO as 8N1 serial on uart_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibus_uart_tx
  import ibus_uart_tx_pkg::*;
#(
  parameter logic [17:0] BASE_ADR    = 18'h0C000,
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic           clk,
  input  logic           rst,
  ibus_uart_tx_if.slave  bus,
  output logic           uart_tx,
  output logic           tx_irq
);

  logic [2:0]       rdec, wdec;
  logic             wr_txdata, wr_status, wr_baud, wr_ctrl, flush;
  logic             fifo_pop, fifo_empty, fifo_full;
  logic [7:0]       fifo_data;
  logic [FIFO_AW:0] fifo_count;
  logic [3:0]       cnt4;
  logic             baud_done;
  logic [15:0]      rdata_d;

  logic [15:0] bauddiv_q, rdata_q, div_q, baud_cnt_q;
  logic        tx_en_q, irq_en_q, ovf_q, irq_q, uart_tx_q;
  logic [7:0]  shreg_q;
  logic [2:0]  bit_cnt_q;
  tx_state_e   state_q;

  assign rdec = win_decode(bus.ibus_radr, BASE_ADR);
  assign wdec = win_decode(bus.ibus_wadr, BASE_ADR);

  assign wr_txdata = bus.ibus_wen & wdec[2] & (wdec[1:0] == REG_TXDATA);
  assign wr_status = bus.ibus_wen & wdec[2] & (wdec[1:0] == REG_STATUS);
  assign wr_baud   = bus.ibus_wen & wdec[2] & (wdec[1:0] == REG_BAUDDIV);
  assign wr_ctrl   = bus.ibus_wen & wdec[2] & (wdec[1:0] == REG_CTRL);
  assign flush     = wr_ctrl & bus.ibus32_wdata[CTRL_FLUSH];
  assign fifo_full = fifo_count[FIFO_AW];
  assign baud_done = (baud_cnt_q == div_q);

  // Pop from IDLE, or on the last STOP cycle so frames run back to back
  assign fifo_pop = tx_en_q & ~fifo_empty & ~flush &
                    ((state_q == TX_IDLE) | ((state_q == TX_STOP) & baud_done));

  // STATUS shows only the low four bits of the occupancy count
  if (FIFO_AW >= 3) begin : g_cnt_wide
    assign cnt4 = fifo_count[3:0];
  end else begin : g_cnt_narrow
    assign cnt4 = {{(3 - FIFO_AW){1'b0}}, fifo_count};
  end

  ibus_tx_fifo #(.FIFO_AW(FIFO_AW), .WIDTH(8)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wr_txdata),
    .push_data_i (bus.ibus32_wdata[7:0]),
    .pop_i       (fifo_pop),
    .flush_i     (flush),
    .pop_data_o  (fifo_data),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Read mux over pre-write register state; unmapped offsets read zero
  always_comb begin
    rdata_d = '0;
    if (rdec[2]) begin
      case (rdec[1:0])
        REG_STATUS: begin
          rdata_d[7:4]     = cnt4;
          rdata_d[ST_OVF]  = ovf_q;
          rdata_d[ST_BUSY] = (state_q != TX_IDLE);
          rdata_d[ST_EMPTY]= fifo_empty;
          rdata_d[ST_FULL] = fifo_full;
        end
        REG_BAUDDIV: rdata_d = bauddiv_q;
        REG_CTRL: begin
          rdata_d[CTRL_TXEN]  = tx_en_q;
          rdata_d[CTRL_IRQEN] = irq_en_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  // Register file, sticky overflow flag, read data and interrupt flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bauddiv_q <= DEFAULT_DIV;
      tx_en_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_baud) bauddiv_q <= bus.ibus32_wdata;
      if (wr_ctrl) begin
        tx_en_q  <= bus.ibus32_wdata[CTRL_TXEN];
        irq_en_q <= bus.ibus32_wdata[CTRL_IRQEN];
      end
      if (wr_status && bus.ibus32_wdata[ST_OVF]) ovf_q <= 1'b0;
      else if (wr_txdata && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      if (bus.ibus_ren) rdata_q <= rdata_d;
      irq_q <= fifo_empty & irq_en_q;
    end
  end

  // TX framing FSM: each bit held div_q+1 clocks, uart_tx driven from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      div_q      <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      uart_tx_q  <= 1'b1;
    end else if (fifo_pop) begin
      state_q    <= TX_START;
      div_q      <= bauddiv_q;
      baud_cnt_q <= '0;
      shreg_q    <= fifo_data;
      uart_tx_q  <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: uart_tx_q <= 1'b1;
        TX_START: begin
          if (baud_done) begin
            state_q    <= TX_DATA;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            uart_tx_q  <= shreg_q[0];
          end else baud_cnt_q <= baud_cnt_q + 1'b1;
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              state_q   <= TX_STOP;
              uart_tx_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              shreg_q   <= shreg_q >> 1;
              uart_tx_q <= shreg_q[1];
            end
          end else baud_cnt_q <= baud_cnt_q + 1'b1;
        end
        TX_STOP: begin
          if (baud_done) state_q <= TX_IDLE;
          else baud_cnt_q <= baud_cnt_q + 1'b1;
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx          = uart_tx_q;
  assign tx_irq           = irq_q;
  assign bus.ibus32_rdata = rdata_q;

endmodule
`default_nettype wire
